// File: rtl/comp_conv_pipe.sv
// comp_conv_pipe: two-stage valid/ready sign-magnitude <-> complement converter with edge-case counters
module comp_conv_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_nzero,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] nzero_cnt,
  input  logic             cnt_clr
);
  localparam int M = WIDTH - 1;
  logic             s1_valid, s2_valid, s1_en, s2_en, fire;
  logic             s1_sign, s1_zero, ovf, nzero;
  logic [1:0]       s1_mode;
  logic [WIDTH-1:0] s1_data, inc, res;
  logic [M-1:0]     s1_inv;
  assign s2_en     = !s2_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid;
  assign fire      = s2_valid && out_ready;
  // {1,~m}+1 is both the two's negation of the magnitude and the low bits of -in_data
  always_comb begin
    inc   = {1'b1, s1_inv} + WIDTH'(1);
    nzero = s1_sign && s1_zero && !s1_mode[1];
    ovf   = s1_sign && s1_zero && s1_mode == 2'b10;
    res   = (!s1_sign || s1_mode == 2'b11) ? s1_data :
            s1_mode == 2'b00 ? {1'b1, s1_inv} :
            s1_mode == 2'b01 ? inc :
            ovf ? '1 : {1'b1, inc[M-1:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_mode   <= '0;
      s1_sign   <= 1'b0;
      s1_inv    <= '0;
      s1_zero   <= 1'b0;
      s2_valid  <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_nzero <= 1'b0;
      ovf_cnt   <= '0;
      nzero_cnt <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= in_valid;
        s1_data  <= in_data;
        s1_mode  <= in_mode;
        s1_sign  <= in_data[WIDTH-1];
        s1_inv   <= ~in_data[M-1:0];
        s1_zero  <= in_data[M-1:0] == '0;
      end
      if (s2_en) begin
        s2_valid  <= s1_valid;
        out_data  <= res;
        out_ovf   <= ovf;
        out_nzero <= nzero;
      end
      if (cnt_clr) ovf_cnt <= '0;
      else if (fire && out_ovf && ovf_cnt != '1) ovf_cnt <= ovf_cnt + CNT_W'(1);
      if (cnt_clr) nzero_cnt <= '0;
      else if (fire && out_nzero && nzero_cnt != '1) nzero_cnt <= nzero_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_comp_conv_pipe.sv
// tb_comp_conv_pipe: directed self-checking bench for comp_conv_pipe
module tb_comp_conv_pipe;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1, cnt_clr = 0;
  logic [7:0]  in_data = 0;
  logic [1:0]  in_mode = 0;
  logic        in_ready, out_valid, out_ovf, out_nzero;
  logic [7:0]  out_data;
  logic [15:0] ovf_cnt, nzero_cnt;
  logic        sm_in_ready, sm_out_valid, sm_out_ovf, sm_out_nzero;
  logic [7:0]  sm_out_data;
  logic [1:0]  sm_ovf_cnt, sm_nzero_cnt;
  int checks = 0, errors = 0;
  comp_conv_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_nzero(out_nzero), .ovf_cnt(ovf_cnt), .nzero_cnt(nzero_cnt),
    .cnt_clr(cnt_clr));
  comp_conv_pipe #(.WIDTH(8), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sm_in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(sm_out_valid), .out_ready(out_ready), .out_data(sm_out_data),
    .out_ovf(sm_out_ovf), .out_nzero(sm_out_nzero), .ovf_cnt(sm_ovf_cnt), .nzero_cnt(sm_nzero_cnt),
    .cnt_clr(cnt_clr));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [9:0] model(input logic [7:0] d, input logic [1:0] md);
    logic s = d[7];
    logic [6:0] m = d[6:0];
    logic [7:0] neg = 8'h00 - d;
    if (!s || md == 2'b11) return {2'b00, d};
    if (md == 2'b00) return {1'b0, m == 0, 1'b1, ~m};
    if (md == 2'b01) return {1'b0, m == 0, 8'h00 - {1'b0, m}};
    if (m == 0) return {2'b10, 8'hFF};
    return {2'b00, 1'b1, neg[6:0]};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic single(input logic [7:0] d, input logic [1:0] md, input logic [7:0] ed,
                        input logic eo, input logic en);
    string t = $sformatf("%0h_m%0d", d, md);
    in_valid = 1; in_data = d; in_mode = md; out_ready = 1;
    #1 check({t, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 0;
    check({t, "_valid_early"}, out_valid, 0);
    tick();
    check({t, "_valid"}, out_valid, 1);
    check({t, "_data"}, out_data, ed);
    check({t, "_ovf"}, out_ovf, eo);
    check({t, "_nzero"}, out_nzero, en);
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] exp4 [4];
    logic [7:0] bd [6];
    logic [1:0] bm [6];
    logic [9:0] q [$];
    logic [9:0] held;
    logic hold;
    int acc, dlv;
    exp4 = '{8'hFA, 8'hFB, 8'hFB, 8'h85};
    tick(); tick();
    rst = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_flags", {out_ovf, out_nzero}, 0);
    check("rst_cnts", {ovf_cnt, nzero_cnt}, 0);
    check("rst_in_ready", in_ready, 1);
    single(8'h85, 2'b00, 8'hFA, 0, 0);
    single(8'h05, 2'b00, 8'h05, 0, 0);
    single(8'h80, 2'b00, 8'hFF, 0, 1);
    check("nzero_cnt_1", nzero_cnt, 1);
    single(8'h85, 2'b01, 8'hFB, 0, 0);
    single(8'hFF, 2'b01, 8'h81, 0, 0);
    single(8'h80, 2'b01, 8'h00, 0, 1);
    check("nzero_cnt_2", nzero_cnt, 2);
    single(8'hFB, 2'b10, 8'h85, 0, 0);
    single(8'h81, 2'b10, 8'hFF, 0, 0);
    single(8'h80, 2'b10, 8'hFF, 1, 0);
    check("ovf_cnt_1", ovf_cnt, 1);
    single(8'h80, 2'b11, 8'h80, 0, 0);
    for (int c = 0; c < 5; c++) begin
      in_valid = c < 4; in_data = 8'h85; in_mode = 2'(c);
      #1 if (c < 4) check($sformatf("b2b_in_ready_%0d", c), in_ready, 1);
      tick();
      if (c >= 1) begin
        check($sformatf("b2b_valid_%0d", c - 1), out_valid, 1);
        check($sformatf("b2b_data_%0d", c - 1), out_data, exp4[c-1]);
      end
    end
    in_valid = 0;
    tick();
    check("b2b_drain", out_valid, 0);
    for (int i = 0; i < 6; i++) begin
      bd[i] = 8'($urandom);
      bm[i] = 2'($urandom_range(0, 3));
    end
    bd[1] = 8'h80; bm[1] = 2'b10;
    acc = 0; dlv = 0; hold = 0; held = 0;
    for (int c = 0; c < 40 && dlv < 6; c++) begin
      out_ready = !(c >= 1 && c <= 3);
      in_valid = acc < 6;
      in_data = bd[acc < 6 ? acc : 0];
      in_mode = bm[acc < 6 ? acc : 0];
      #1;
      if (c == 2) begin
        check("bp_in_ready_low", in_ready, 0);
        check("bp_accepted", acc, 2);
      end
      if (hold) check($sformatf("bp_stable_%0d", c), {out_ovf, out_nzero, out_data}, held);
      hold = out_valid && !out_ready;
      held = {out_ovf, out_nzero, out_data};
      if (in_valid && in_ready) begin
        q.push_back(model(in_data, in_mode));
        acc++;
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp_beat_%0d", dlv), {out_ovf, out_nzero, out_data}, q.pop_front());
        dlv++;
      end
      tick();
    end
    in_valid = 0;
    check("bp_delivered", dlv, 6);
    out_ready = 0;
    in_valid = 1; in_data = 8'h80; in_mode = 2'b00;
    tick(); tick();
    in_valid = 0;
    #1 check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_cnts", {ovf_cnt, nzero_cnt}, 0);
    out_ready = 1;
    tick(); tick();
    check("mid_rst_no_ghost", out_valid, 0);
    single(8'h80, 2'b10, 8'hFF, 1, 0);
    check("clr_pre_cnt", ovf_cnt, 1);
    in_valid = 1; in_data = 8'h80; in_mode = 2'b10;
    tick();
    in_valid = 0;
    tick();
    check("clr_flag", out_ovf, 1);
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    check("clr_coincident", ovf_cnt, 0);
    check("clr_small", sm_ovf_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = 8'h80; in_mode = 2'b10;
      tick();
    end
    in_valid = 0;
    tick(); tick(); tick();
    check("sat_wide", ovf_cnt, 4);
    check("sat_small", sm_ovf_cnt, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
